serial_borrow_sub: RTL and testbench

- Parametrised multi-cycle subtractor: computes D = x − y on WIDTH-bit operands, DIGIT bits per clock.
- Each digit uses the half/full-subtractor borrow relation; borrow is carried between cycles in a register.
- Start/busy/done handshake. Reports final borrow out and signed overflow.
- Serves as the sequential, width-generalised successor to the team's single-bit subtractor cells.

---
 rtl/serial_borrow_sub.sv | 171 +++++++++++++++++
 tb/tb_serial_borrow_sub.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_sub.sv
// Digit-serial subtractor: D = x - y over WIDTH bits, DIGIT bits per clock, borrow held between cycles.
// start is honoured in IDLE/DONE only; D/B/ovf change only on the completing edge.
module serial_borrow_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B,
  output logic             ovf
);

  localparam int CYC   = WIDTH / DIGIT;
  localparam int CNT_W = (CYC > 1) ? $clog2(CYC) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_borrow_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic             x_msb_q, x_msb_d;
  logic             y_msb_q, y_msb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             b_q, b_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             run_step;
  logic             last;
  logic [DIGIT:0]   diff;
  logic [WIDTH-1:0] res_next;

  assign accept   = (state_q == S_IDLE || state_q == S_DONE) && start;
  assign run_step = (state_q == S_RUN);
  assign last     = (cnt_q == CNT_W'(CYC - 1));

  // Digit subtract with borrow-in; the extra top bit is the borrow-out.
  assign diff = {1'b0, xs_q[DIGIT-1:0]} - {1'b0, ys_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};

  // Result shift register holds the digits finished so far, top-aligned.
  generate
    if (DIGIT < WIDTH) begin : g_res
      logic [WIDTH-DIGIT-1:0] res_q, res_d;

      assign res_next = {diff[DIGIT-1:0], res_q};

      always_comb begin
        res_d = res_q;
        if (accept) begin
          res_d = '0;
        end else if (run_step) begin
          res_d = res_next[WIDTH-1:DIGIT];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_q <= '0;
        end else begin
          res_q <= res_d;
        end
      end
    end else begin : g_res_single
      assign res_next = diff[DIGIT-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode straight off the state register
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    xs_d     = xs_q;
    ys_d     = ys_q;
    x_msb_d  = x_msb_q;
    y_msb_d  = y_msb_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    b_d      = b_q;
    ovf_d    = ovf_q;
    if (accept) begin
      xs_d     = x;
      ys_d     = y;
      x_msb_d  = x[WIDTH-1];
      y_msb_d  = y[WIDTH-1];
      cnt_d    = '0;
      borrow_d = 1'b0;
    end else if (run_step) begin
      xs_d     = xs_q >> DIGIT;
      ys_d     = ys_q >> DIGIT;
      borrow_d = diff[DIGIT];
      cnt_d    = cnt_q + CNT_W'(1);
      if (last) begin
        d_d   = res_next;
        b_d   = diff[DIGIT];
        ovf_d = (x_msb_q != y_msb_q) && (res_next[WIDTH-1] != x_msb_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q     <= '0;
      ys_q     <= '0;
      x_msb_q  <= 1'b0;
      y_msb_q  <= 1'b0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      b_q      <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      x_msb_q  <= x_msb_d;
      y_msb_q  <= y_msb_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      b_q      <= b_d;
      ovf_q    <= ovf_d;
    end
  end

  assign D   = d_q;
  assign B   = b_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_serial_borrow_sub.sv
// Bench for serial_borrow_sub: directed cases on the 8/1 instance, random regression on eight configurations.
module tb_serial_borrow_sub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0]       start_a = '0;
  logic [7:0][15:0] x_a = '0;
  logic [7:0][15:0] y_a = '0;
  logic [7:0][15:0] d_a;
  logic [7:0]       busy_a, done_a, b_a, ovf_a;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instances 0..3: WIDTH 8, 4..7: WIDTH 16; DIGIT = 1,2,4,8 within each group.
  for (genvar g = 0; g < 8; g++) begin : g_dut
    localparam int W  = (g < 4) ? 8 : 16;
    localparam int DG = 1 << (g % 4);
    logic [W-1:0] d_w;
    serial_borrow_sub #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start_a[g]),
      .x    (x_a[g][W-1:0]),
      .y    (y_a[g][W-1:0]),
      .busy (busy_a[g]),
      .done (done_a[g]),
      .D    (d_w),
      .B    (b_a[g]),
      .ovf  (ovf_a[g])
    );
    assign d_a[g] = 16'(d_w);
  end

  function automatic int wid(input int i);
    return (i < 4) ? 8 : 16;
  endfunction

  function automatic int cyc(input int i);
    return wid(i) / (1 << (i % 4));
  endfunction

  // Reference: plain integer arithmetic on the operands.
  task automatic ref_sub(input int w, input logic [15:0] xi, input logic [15:0] yi,
                         output logic [15:0] d, output logic b, output logic o);
    longint full = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint xl = longint'(xi) & (full - 1);
    longint yl = longint'(yi) & (full - 1);
    longint sx = (xl >= half) ? xl - full : xl;
    longint sy = (yl >= half) ? yl - full : yl;
    longint sd = sx - sy;
    longint ud = (xl - yl + full) % full;
    d = 16'(ud);
    b = (xl < yl);
    o = (sd >= half) || (sd < -half);
  endtask

  // One start pulse on instance 0; reports busy length, done length and result.
  task automatic do_op(input logic [7:0] xi, input logic [7:0] yi,
                       output int blen, output int dlen,
                       output logic [7:0] d, output logic b, output logic o, output bit held);
    logic [15:0] d0;
    logic b0, o0;
    @(negedge clk);
    d0 = d_a[0]; b0 = b_a[0]; o0 = ovf_a[0];
    x_a[0] = 16'(xi); y_a[0] = 16'(yi); start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    blen = 0; dlen = 0; held = 1'b1; d = 'x; b = 1'bx; o = 1'bx;
    while (busy_a[0] === 1'b1 && blen < 40) begin
      blen++;
      if (d_a[0] !== d0 || b_a[0] !== b0 || ovf_a[0] !== o0) held = 1'b0;
      @(negedge clk);
    end
    while (done_a[0] === 1'b1 && dlen < 5) begin
      dlen++;
      d = d_a[0][7:0]; b = b_a[0]; o = ovf_a[0];
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (busy_a !== 8'h00 || done_a !== 8'h00 || b_a !== 8'h00 || ovf_a !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%h done=%h B=%h ovf=%h, required all 00", busy_a, done_a, b_a, ovf_a);
    end
    n_tests++;
    if (d_a !== '0) begin
      n_fail++;
      $display("FAIL reset_D: got %h, required 0", d_a);
    end
    // start coincident with reset must be lost
    @(negedge clk);
    start_a[0] = 1'b1; x_a[0] = 16'h5A; y_a[0] = 16'h3C;
    @(negedge clk);
    n_tests++;
    if (busy_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vs_start: busy=%b, required 0", busy_a[0]);
    end
    start_a[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy_a[0], done_a[0]);
    end
  endtask

  task automatic test_basic;
    logic [7:0] tx[6] = '{8'h5A, 8'h3C, 8'h80, 8'h7F, 8'h00, 8'hA5};
    logic [7:0] ty[6] = '{8'h3C, 8'h5A, 8'h01, 8'hFF, 8'h01, 8'hA5};
    logic [7:0] td[6] = '{8'h1E, 8'hE2, 8'h7F, 8'h80, 8'hFF, 8'h00};
    logic       tb[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       to[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int blen, dlen;
    logic [7:0] d;
    logic b, o;
    bit held;
    for (int k = 0; k < 6; k++) begin
      do_op(tx[k], ty[k], blen, dlen, d, b, o, held);
      n_tests++;
      if (blen != 8) begin
        n_fail++;
        $display("FAIL basic_busy_len[%0d]: got %0d, required 8", k, blen);
      end
      n_tests++;
      if (dlen != 1) begin
        n_fail++;
        $display("FAIL basic_done_len[%0d]: got %0d, required 1", k, dlen);
      end
      n_tests++;
      if (!held) begin
        n_fail++;
        $display("FAIL basic_hold[%0d]: outputs changed during RUN", k);
      end
      n_tests++;
      if (d !== td[k] || b !== tb[k] || o !== to[k]) begin
        n_fail++;
        $display("FAIL basic_result[%0d] %h-%h: got D=%h B=%b ovf=%b, required D=%h B=%b ovf=%b",
                 k, tx[k], ty[k], d, b, o, td[k], tb[k], to[k]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int blen = 0;
    logic [7:0] d;
    logic b, o, seen;
    @(negedge clk);
    x_a[0] = 16'h5A; y_a[0] = 16'h3C; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    while (busy_a[0] === 1'b1 && blen < 40) begin
      blen++;
      start_a[0] = (blen == 3);
      if (blen == 3) begin
        x_a[0] = 16'hFF; y_a[0] = 16'h00;
      end
      @(negedge clk);
    end
    start_a[0] = 1'b0;
    seen = done_a[0]; d = d_a[0][7:0]; b = b_a[0]; o = ovf_a[0];
    @(negedge clk);
    n_tests++;
    if (blen != 8) begin
      n_fail++;
      $display("FAIL ignore_busy_len: got %0d, required 8", blen);
    end
    n_tests++;
    if (seen !== 1'b1 || d !== 8'h1E || b !== 1'b0 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got done=%b D=%h B=%b ovf=%b, required 1 1e 0 0", seen, d, b, o);
    end
    n_tests++;
    if (busy_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_restart: busy=%b, required 0", busy_a[0]);
    end
  endtask

  task automatic test_back_to_back;
    int blen1 = 0, blen2 = 0;
    logic seen1;
    logic [7:0] d1;
    @(negedge clk);
    x_a[0] = 16'h3C; y_a[0] = 16'h5A; start_a[0] = 1'b1;
    @(negedge clk);
    while (busy_a[0] === 1'b1 && blen1 < 40) begin
      blen1++;
      @(negedge clk);
    end
    seen1 = done_a[0]; d1 = d_a[0][7:0];
    x_a[0] = 16'h80; y_a[0] = 16'h01;
    @(negedge clk);
    n_tests++;
    if (busy_a[0] !== 1'b1 || done_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_idle_gap: busy=%b done=%b, required 1 0", busy_a[0], done_a[0]);
    end
    start_a[0] = 1'b0;
    while (busy_a[0] === 1'b1 && blen2 < 40) begin
      blen2++;
      @(negedge clk);
    end
    n_tests++;
    if (blen1 != 8 || blen2 != 8 || seen1 !== 1'b1 || d1 !== 8'hE2) begin
      n_fail++;
      $display("FAIL b2b_first: busy lens %0d/%0d done=%b D=%h, required 8/8 1 e2", blen1, blen2, seen1, d1);
    end
    n_tests++;
    if (done_a[0] !== 1'b1 || d_a[0] !== 16'h007F || b_a[0] !== 1'b0 || ovf_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b D=%h B=%b ovf=%b, required 1 7f 0 1",
               done_a[0], d_a[0], b_a[0], ovf_a[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int blen = 0, late = 0, dlen;
    logic [7:0] d;
    logic b, o;
    bit held;
    @(negedge clk);
    x_a[0] = 16'h3C; y_a[0] = 16'h5A; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    while (busy_a[0] === 1'b1 && blen < 3) begin
      blen++;
      @(negedge clk);
    end
    // now in the 4th RUN cycle; previous result D=7f ovf=1 is still visible
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || d_a[0] !== 16'h0 || b_a[0] !== 1'b0 || ovf_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_async: busy=%b done=%b D=%h B=%b ovf=%b, required all 0",
               busy_a[0], done_a[0], d_a[0], b_a[0], ovf_a[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0) late++;
      @(negedge clk);
    end
    n_tests++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: %0d active cycles after reset, required 0", late);
    end
    do_op(8'h00, 8'h01, blen, dlen, d, b, o, held);
    n_tests++;
    if (blen != 8 || dlen != 1 || d !== 8'hFF || b !== 1'b1 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_recover: busy=%0d done=%0d D=%h B=%b ovf=%b, required 8 1 ff 1 0",
               blen, dlen, d, b, o);
    end
  endtask

  task automatic test_random;
    int rem[8];
    bit dn[8];
    int ops[8];
    logic [15:0] ed[8], pd[8];
    logic eb[8], eo[8], pb[8], po[8];
    bit acc[8];
    int cycles = 0;
    bit all_done = 1'b0;
    @(negedge clk);
    rst = 1'b1; start_a = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rem[i] = 0; dn[i] = 1'b0; ops[i] = 0; ed[i] = '0; eb[i] = 1'b0; eo[i] = 1'b0;
      pd[i] = '0; pb[i] = 1'b0; po[i] = 1'b0;
    end
    while (!all_done && cycles < 40000 && n_fail < 50) begin
      for (int i = 0; i < 8; i++) begin
        start_a[i] = ($urandom_range(0, 7) != 0);
        x_a[i] = 16'($urandom);
        y_a[i] = 16'($urandom);
        acc[i] = start_a[i] && (rem[i] == 0);
        if (acc[i]) ref_sub(wid(i), x_a[i], y_a[i], pd[i], pb[i], po[i]);
      end
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        if (acc[i]) begin
          rem[i] = cyc(i); dn[i] = 1'b0;
        end else if (rem[i] > 0) begin
          rem[i]--;
          dn[i] = (rem[i] == 0);
          if (dn[i]) begin
            ed[i] = pd[i]; eb[i] = pb[i]; eo[i] = po[i]; ops[i]++;
          end
        end else begin
          dn[i] = 1'b0;
        end
      end
      @(negedge clk);
      all_done = 1'b1;
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (busy_a[i] !== (rem[i] > 0) || done_a[i] !== dn[i]) begin
          n_fail++;
          $display("FAIL rand_timing[W%0d/DIG%0d] cycle %0d: busy=%b done=%b, required %b %b",
                   wid(i), 1 << (i % 4), cycles, busy_a[i], done_a[i], rem[i] > 0, dn[i]);
        end
        n_tests++;
        if (d_a[i] !== ed[i] || b_a[i] !== eb[i] || ovf_a[i] !== eo[i]) begin
          n_fail++;
          $display("FAIL rand_result[W%0d/DIG%0d] cycle %0d: D=%h B=%b ovf=%b, required D=%h B=%b ovf=%b",
                   wid(i), 1 << (i % 4), cycles, d_a[i], b_a[i], ovf_a[i], ed[i], eb[i], eo[i]);
        end
        if (ops[i] < 1000) all_done = 1'b0;
      end
      cycles++;
    end
    start_a = '0;
    n_tests++;
    if (!all_done) begin
      n_fail++;
      $display("FAIL rand_completion: stopped after %0d cycles, ops[7]=%0d, required 1000 per config",
               cycles, ops[7]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
